// File: rtl/state_update_sequencer_pkg.sv
// Shared types and dimensions for the Kalman measurement-update sequencer.
// Words are IEEE-754 doubles carried as opaque bit patterns.
package state_update_sequencer_pkg;
   localparam int VEC_WIDTH = 64;
   localparam int MAT_DIM   = 12;
   localparam int MEAS_DIM  = 6;

   typedef logic [VEC_WIDTH-1:0] fp64_t;
   typedef fp64_t [MAT_DIM-1:0]  vec12_t;
   typedef fp64_t [MEAS_DIM-1:0] vec6_t;

   typedef enum logic [2:0] {IDLE, COLLECT, WAIT_GAIN, WAIT_DONE, DRAIN} sus_state_e;
endpackage

// File: rtl/state_update_sequencer_if.sv
// Host/predictor-facing signal bundle of the sequencer; slave is the sequencer side.
interface state_update_sequencer_if;
   import state_update_sequencer_pkg::*;

   logic   x0_load;
   vec12_t x0;
   logic   meas_valid;
   logic   meas_ready;
   fp64_t  meas_data;
   logic   gain_valid;
   logic   sp_init_valid;
   logic   sp_done;
   vec6_t  z_k;
   vec12_t x_kk1;
   vec12_t x_kk;
   logic   est_valid;
   logic   est_ready;
   fp64_t  est_data;
   logic   est_last;
   logic   busy;
   logic   err_timeout;

   modport slave (
      input  x0_load, x0, meas_valid, meas_data, gain_valid, sp_done, x_kk, est_ready,
      output meas_ready, sp_init_valid, z_k, x_kk1, est_valid, est_data, est_last, busy, err_timeout
   );

   modport master (
      output x0_load, x0, meas_valid, meas_data, gain_valid, sp_done, x_kk, est_ready,
      input  meas_ready, sp_init_valid, z_k, x_kk1, est_valid, est_data, est_last, busy, err_timeout
   );
endinterface

// File: rtl/state_update_sequencer_vec_serializer.sv
// Parallel-load MAT_DIM-word buffer streamed out word 0 first on a valid/ready port.
// Valid stays high and data holds until each word is taken.
module vec_serializer
   import state_update_sequencer_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  vec12_t din,
   input  logic   ready,
   output logic   valid,
   output fp64_t  data,
   output logic   last,
   output logic   done
);
   localparam int IW = $clog2(MAT_DIM);

   vec12_t        buf_q;
   logic [IW-1:0] idx;
   logic          active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q  <= '0;
         idx    <= '0;
         active <= 1'b0;
      end else if (load) begin
         buf_q  <= din;
         idx    <= '0;
         active <= 1'b1;
      end else if (active && ready) begin
         if (idx == IW'(MAT_DIM-1)) begin
            idx    <= '0;
            active <= 1'b0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign valid = active;
   assign data  = buf_q[idx];
   assign last  = active && (idx == IW'(MAT_DIM-1));
   assign done  = last && ready;
endmodule

// File: rtl/state_update_sequencer.sv
// Host-side sequencer for the Kalman measurement update: gathers Z_k, holds Z_k/X_kk1 for the
// predictor while Init_Valid is up, then streams X_kk out and keeps it as the next prior.
module state_update_sequencer
   import state_update_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input logic clk,
   input logic rst_n,
   state_update_sequencer_if.slave bus
);
   localparam int MIW = $clog2(MEAS_DIM);
   localparam int TW  = $clog2(TIMEOUT);

   sus_state_e     state, state_nxt;
   logic [MIW-1:0] meas_idx;
   logic [TW-1:0]  tcnt;
   vec6_t          z_reg;
   vec12_t         x_reg;
   logic           err_q;
   logic           meas_ready, sp_init_valid, busy;
   logic           meas_acc, done_acc, tmo, x0_take;
   logic           ser_valid, ser_last, ser_done;
   fp64_t          ser_data;

   assign meas_acc = bus.meas_valid && meas_ready;
   assign done_acc = (state == WAIT_DONE) && bus.sp_done;
   assign tmo      = (state == WAIT_DONE) && !bus.sp_done && (tcnt == TW'(TIMEOUT-1));
   assign x0_take  = (state == IDLE) && bus.x0_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (meas_acc) state_nxt = COLLECT;
         COLLECT:   if (meas_acc && meas_idx == MIW'(MEAS_DIM-1)) state_nxt = WAIT_GAIN;
         WAIT_GAIN: if (bus.gain_valid) state_nxt = WAIT_DONE;
         WAIT_DONE: if (done_acc) state_nxt = DRAIN;
                    else if (tmo) state_nxt = IDLE;
         DRAIN:     if (ser_done) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // meas_ready is gated by rst_n so it reads 0 while reset is held, not just after it.
   always_comb begin
      meas_ready    = rst_n && (state == IDLE || state == COLLECT);
      sp_init_valid = (state == WAIT_DONE);
      busy          = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_reg    <= '0;
         x_reg    <= '0;
         meas_idx <= '0;
         tcnt     <= '0;
         err_q    <= 1'b0;
      end else begin
         // x0_load and sp_done capture cannot coincide: one needs IDLE, the other WAIT_DONE.
         if (x0_take)       x_reg <= bus.x0;
         else if (done_acc) x_reg <= bus.x_kk;
         if (meas_acc) begin
            z_reg[meas_idx] <= bus.meas_data;
            meas_idx        <= (meas_idx == MIW'(MEAS_DIM-1)) ? '0 : meas_idx + 1'b1;
         end
         tcnt <= (state == WAIT_DONE) ? tcnt + 1'b1 : '0;
         if (tmo)          err_q <= 1'b1;
         else if (x0_take) err_q <= 1'b0;
      end
   end

   vec_serializer u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (done_acc),
      .din   (bus.x_kk),
      .ready (bus.est_ready),
      .valid (ser_valid),
      .data  (ser_data),
      .last  (ser_last),
      .done  (ser_done)
   );

   assign bus.meas_ready    = meas_ready;
   assign bus.sp_init_valid = sp_init_valid;
   assign bus.busy          = busy;
   assign bus.z_k           = z_reg;
   assign bus.x_kk1         = x_reg;
   assign bus.err_timeout   = err_q;
   assign bus.est_valid     = ser_valid;
   assign bus.est_data      = ser_data;
   assign bus.est_last      = ser_last;
endmodule

// File: tb/tb_state_update_sequencer.sv
// Randomized bench for state_update_sequencer against a transaction-level model of the update loop.
module tb_state_update_sequencer;
   import state_update_sequencer_pkg::*;

   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;
   vec12_t model_x = '0;

   always #5 clk = ~clk;

   state_update_sequencer_if bus();
   state_update_sequencer #(.TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic fp64_t rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic vec12_t rnd_vec12();
      vec12_t v;
      for (int i = 0; i < MAT_DIM; i++) v[i] = rnd64();
      return v;
   endfunction

   function automatic vec6_t rnd_vec6();
      vec6_t v;
      for (int i = 0; i < MEAS_DIM; i++) v[i] = rnd64();
      return v;
   endfunction

   // Offers the six measurement words; optional idle gaps and x0_load alongside word 0.
   task automatic feed_meas(input vec6_t z, input bit gaps, input bit with_load, input vec12_t x0v,
                            output int bad);
      int w;
      bad = 0;
      for (int k = 0; k < MEAS_DIM; k++) begin
         if (gaps) begin
            bus.meas_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
         bus.meas_valid = 1'b1;
         bus.meas_data  = z[k];
         if (k == 0 && with_load) begin
            bus.x0_load = 1'b1;
            bus.x0      = x0v;
         end
         w = 0;
         while (bus.meas_ready !== 1'b1 && w < 50) begin tick(); w++; end
         if (w == 50) bad++;
         tick();
         bus.x0_load = 1'b0;
      end
      bus.meas_valid = 1'b0;
   endtask

   // Entered in WAIT_DONE; counts cycles where the predictor-facing hold is broken, then fires sp_done.
   task automatic run_predictor(input int dly, input vec12_t xk, input vec6_t zexp, input bit wiggle,
                                output int bad);
      bad = 0;
      for (int c = 0; c < dly; c++) begin
         if (bus.sp_init_valid !== 1'b1 || bus.x_kk1 !== model_x || bus.z_k !== zexp) bad++;
         if (wiggle) bus.gain_valid = 1'($urandom_range(0, 1));
         tick();
      end
      bus.sp_done = 1'b1;
      bus.x_kk    = xk;
      tick();
      bus.sp_done    = 1'b0;
      bus.gain_valid = 1'b0;
      bus.x_kk       = rnd_vec12();
   endtask

   // Takes MAT_DIM words from the estimate port, tallying wrong words, est_last use and hold breaches.
   task automatic drain(input vec12_t exp_v, input int stall_at, input int stall_len, input bit rnd,
                        output int word_bad, output int n_last, output int last_pos,
                        output int hold_bad, output int ntaken);
      int stalled = 0;
      int cyc = 0;
      bit pend = 1'b0;
      fp64_t prev = '0;
      word_bad = 0; n_last = 0; last_pos = -1; hold_bad = 0; ntaken = 0;
      while (ntaken < MAT_DIM && cyc < 400) begin
         cyc++;
         if (bus.est_valid !== 1'b1) hold_bad++;
         if (pend && bus.est_data !== prev) hold_bad++;
         if (ntaken == stall_at && stalled < stall_len) begin
            bus.est_ready = 1'b0;
            stalled++;
         end else begin
            bus.est_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (bus.est_valid === 1'b1 && bus.est_ready) begin
            if (bus.est_data !== exp_v[ntaken]) word_bad++;
            if (bus.est_last === 1'b1) begin n_last++; last_pos = ntaken; end
            ntaken++;
         end
         pend = !bus.est_ready;
         prev = bus.est_data;
         tick();
      end
      bus.est_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.x0_load = 0; bus.x0 = '0; bus.meas_valid = 0; bus.meas_data = '0; bus.gain_valid = 0;
      bus.sp_done = 0; bus.x_kk = '0; bus.est_ready = 0;
      rst_n = 1'b0;
      tick(); tick();
      n_checks++; if (bus.meas_ready !== 1'b0) begin n_err++; $display("FAIL reset_meas_ready got=%0b exp=0", bus.meas_ready); end
      n_checks++; if (bus.busy !== 1'b0 || bus.sp_init_valid !== 1'b0 || bus.est_valid !== 1'b0 || bus.est_last !== 1'b0) begin n_err++; $display("FAIL reset_flags busy=%0b init=%0b est_valid=%0b last=%0b exp all 0", bus.busy, bus.sp_init_valid, bus.est_valid, bus.est_last); end
      n_checks++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_err got=%0b exp=0", bus.err_timeout); end
      n_checks++; if (bus.z_k !== '0 || bus.x_kk1 !== '0 || bus.est_data !== '0) begin n_err++; $display("FAIL reset_data z0=%h x0=%h est=%h exp 0", bus.z_k[0], bus.x_kk1[0], bus.est_data); end
      rst_n = 1'b1;
      model_x = '0;
      tick();
      n_checks++; if (bus.meas_ready !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset ready=%0b busy=%0b exp 1/0", bus.meas_ready, bus.busy); end
   endtask

   task automatic test_basic();
      vec12_t x0v, xk;
      vec6_t z;
      int bad, wb, nl, lp, hb, nt;
      for (int i = 0; i < MAT_DIM; i++) begin
         x0v[i] = $realtobits(real'(i) + 1.0);
         xk[i]  = $realtobits(100.0 + real'(i));
      end
      for (int i = 0; i < MEAS_DIM; i++) z[i] = $realtobits(10.0 + real'(i));
      feed_meas(z, 1'b0, 1'b1, x0v, bad);
      model_x = x0v;
      n_checks++; if (bad !== 0) begin n_err++; $display("FAIL basic_meas_accept stalls=%0d exp=0", bad); end
      n_checks++; if (bus.z_k !== z || bus.x_kk1 !== model_x) begin n_err++; $display("FAIL basic_hold z0=%h x0=%h exp %h %h", bus.z_k[0], bus.x_kk1[0], z[0], model_x[0]); end
      n_checks++; if (bus.meas_ready !== 1'b0 || bus.sp_init_valid !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_wait_gain ready=%0b init=%0b busy=%0b exp 0/0/1", bus.meas_ready, bus.sp_init_valid, bus.busy); end
      bus.gain_valid = 1'b1;
      tick();
      n_checks++; if (bus.sp_init_valid !== 1'b1) begin n_err++; $display("FAIL basic_init_latency got=%0b exp=1", bus.sp_init_valid); end
      run_predictor(20, xk, z, 1'b0, bad);
      n_checks++; if (bad !== 0) begin n_err++; $display("FAIL basic_wait_done_hold bad_cycles=%0d exp=0", bad); end
      n_checks++; if (bus.est_valid !== 1'b1 || bus.sp_init_valid !== 1'b0) begin n_err++; $display("FAIL basic_done_latency est_valid=%0b init=%0b exp 1/0", bus.est_valid, bus.sp_init_valid); end
      model_x = xk;
      n_checks++; if (bus.x_kk1 !== model_x) begin n_err++; $display("FAIL basic_state_capture got=%h exp=%h", bus.x_kk1[0], model_x[0]); end
      drain(xk, -1, 0, 1'b0, wb, nl, lp, hb, nt);
      n_checks++; if (nt !== MAT_DIM || wb !== 0) begin n_err++; $display("FAIL basic_words taken=%0d wrong=%0d exp %0d/0", nt, wb, MAT_DIM); end
      n_checks++; if (nl !== 1 || lp !== MAT_DIM-1) begin n_err++; $display("FAIL basic_last count=%0d pos=%0d exp 1/%0d", nl, lp, MAT_DIM-1); end
      n_checks++; if (bus.busy !== 1'b0 || bus.est_valid !== 1'b0 || bus.meas_ready !== 1'b1) begin n_err++; $display("FAIL basic_back_idle busy=%0b est_valid=%0b ready=%0b exp 0/0/1", bus.busy, bus.est_valid, bus.meas_ready); end
   endtask

   task automatic test_second_update();
      vec12_t xk = rnd_vec12();
      vec6_t z = rnd_vec6();
      int bad, wb, nl, lp, hb, nt;
      feed_meas(z, 1'b0, 1'b0, '0, bad);
      n_checks++; if (bus.x_kk1 !== model_x) begin n_err++; $display("FAIL second_prior got=%h exp=%h", bus.x_kk1[0], model_x[0]); end
      bus.gain_valid = 1'b1;
      tick();
      run_predictor($urandom_range(1, 30), xk, z, 1'b0, bad);
      n_checks++; if (bad !== 0) begin n_err++; $display("FAIL second_hold bad_cycles=%0d exp=0", bad); end
      model_x = xk;
      drain(xk, -1, 0, 1'b1, wb, nl, lp, hb, nt);
      n_checks++; if (nt !== MAT_DIM || wb !== 0 || hb !== 0) begin n_err++; $display("FAIL second_words taken=%0d wrong=%0d hold=%0d exp %0d/0/0", nt, wb, hb, MAT_DIM); end
      n_checks++; if (bus.x_kk1 !== model_x) begin n_err++; $display("FAIL second_feedback got=%h exp=%h", bus.x_kk1[0], model_x[0]); end
   endtask

   task automatic test_gain_delay();
      vec12_t xk = rnd_vec12();
      vec6_t z = rnd_vec6();
      int bad, early, wb, nl, lp, hb, nt;
      feed_meas(z, 1'b1, 1'b0, '0, bad);
      n_checks++; if (bad !== 0 || bus.z_k !== z) begin n_err++; $display("FAIL gaps_collect stalls=%0d z5=%h exp 0 %h", bad, bus.z_k[5], z[5]); end
      early = 0;
      for (int c = 0; c < 50; c++) begin
         bus.sp_done = (c == 10);
         bus.x0_load = (c == 20);
         bus.x0      = rnd_vec12();
         if (bus.sp_init_valid !== 1'b0 || bus.est_valid !== 1'b0 || bus.busy !== 1'b1) early++;
         tick();
      end
      bus.sp_done = 1'b0; bus.x0_load = 1'b0;
      n_checks++; if (early !== 0) begin n_err++; $display("FAIL gain_wait_early bad_cycles=%0d exp=0", early); end
      n_checks++; if (bus.x_kk1 !== model_x) begin n_err++; $display("FAIL x0_load_ignored got=%h exp=%h", bus.x_kk1[0], model_x[0]); end
      bus.gain_valid = 1'b1;
      tick();
      run_predictor($urandom_range(10, 40), xk, z, 1'b1, bad);
      n_checks++; if (bad !== 0) begin n_err++; $display("FAIL init_level bad_cycles=%0d exp=0", bad); end
      model_x = xk;
      drain(xk, -1, 0, 1'b1, wb, nl, lp, hb, nt);
      n_checks++; if (nt !== MAT_DIM || wb !== 0 || nl !== 1) begin n_err++; $display("FAIL gain_delay_words taken=%0d wrong=%0d last=%0d exp %0d/0/1", nt, wb, nl, MAT_DIM); end
   endtask

   task automatic test_stall();
      vec12_t xk = rnd_vec12();
      vec6_t z = rnd_vec6();
      int bad, wb, nl, lp, hb, nt;
      feed_meas(z, 1'b0, 1'b0, '0, bad);
      bus.gain_valid = 1'b1;
      tick();
      run_predictor(5, xk, z, 1'b0, bad);
      model_x = xk;
      drain(xk, 4, 5, 1'b0, wb, nl, lp, hb, nt);
      n_checks++; if (hb !== 0) begin n_err++; $display("FAIL stall_hold breaches=%0d exp=0", hb); end
      n_checks++; if (nt !== MAT_DIM || wb !== 0 || nl !== 1 || lp !== MAT_DIM-1) begin n_err++; $display("FAIL stall_words taken=%0d wrong=%0d last=%0d@%0d exp %0d/0/1@%0d", nt, wb, nl, lp, MAT_DIM, MAT_DIM-1); end
      n_checks++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stall_idle busy=%0b exp=0", bus.busy); end
   endtask

   task automatic test_timeout();
      vec6_t z = rnd_vec6();
      vec12_t x0v = rnd_vec12();
      int bad, n;
      feed_meas(z, 1'b0, 1'b0, '0, bad);
      bus.gain_valid = 1'b1;
      tick();
      bus.gain_valid = 1'b0;
      n = 0;
      while (bus.sp_init_valid === 1'b1 && n < 200) begin n++; tick(); end
      n_checks++; if (n !== TMO) begin n_err++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TMO); end
      n_checks++; if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL timeout_flag err=%0b busy=%0b exp 1/0", bus.err_timeout, bus.busy); end
      n_checks++; if (bus.x_kk1 !== model_x) begin n_err++; $display("FAIL timeout_state got=%h exp=%h", bus.x_kk1[0], model_x[0]); end
      repeat (3) tick();
      n_checks++; if (bus.err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got=%0b exp=1", bus.err_timeout); end
      bus.x0_load = 1'b1; bus.x0 = x0v;
      tick();
      bus.x0_load = 1'b0;
      model_x = x0v;
      n_checks++; if (bus.err_timeout !== 1'b0 || bus.x_kk1 !== model_x) begin n_err++; $display("FAIL x0_clear err=%0b x=%h exp 0 %h", bus.err_timeout, bus.x_kk1[0], model_x[0]); end
   endtask

   task automatic test_reset_mid();
      vec6_t z = rnd_vec6();
      int bad;
      feed_meas(z, 1'b0, 1'b0, '0, bad);
      bus.gain_valid = 1'b1;
      tick();
      repeat (7) tick();
      n_checks++; if (bus.sp_init_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_reset init=%0b exp=1", bus.sp_init_valid); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.sp_init_valid !== 1'b0 || bus.busy !== 1'b0 || bus.meas_ready !== 1'b0 || bus.est_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_ctrl init=%0b busy=%0b ready=%0b est=%0b exp 0", bus.sp_init_valid, bus.busy, bus.meas_ready, bus.est_valid); end
      n_checks++; if (bus.z_k !== '0 || bus.x_kk1 !== '0 || bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL async_reset_data z0=%h x0=%h err=%0b exp 0", bus.z_k[0], bus.x_kk1[0], bus.err_timeout); end
      bus.gain_valid = 1'b0;
      model_x = '0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_second_update();
      test_gain_delay();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_basic();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
